// File: rtl/alu_op_seq.sv
// rtl/alu_op_seq.sv - multi-cycle ALU op sequencer owning the 8085 ACC and PSW flags
// Latches operands into an external combinational ALU, waits EXEC_CYC cycles, writes back.
module alu_op_seq #(
  parameter int EXEC_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] op,
  input  logic [7:0] opnd,
  output logic       ack,
  output logic       busy,
  input  logic       acc_wr,
  input  logic [7:0] acc_din,
  input  logic       flg_wr,
  input  logic [7:0] flg_din,
  output logic [7:0] acc,
  output logic [7:0] flg,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_c,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_res,
  input  logic [7:0] alu_flg
);

  if (EXEC_CYC < 1 || EXEC_CYC > 15) begin : g_exec_cyc_range
    $error("alu_op_seq: EXEC_CYC must be in 1..15");
  end

  localparam logic [2:0] OP_CMP   = 3'b111;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WBACK = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] flg_q, flg_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [1:0] c_q, c_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] res_q, res_d;
  logic [7:0] fq_q, fq_d;

  // PSW layout {S,Z,0,AC,0,P,1,CY}: the constant bits are forced on every flag write.
  function automatic logic [7:0] norm_flg(input logic [7:0] f);
    return (f & 8'hD7) | 8'h02;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      flg_q   <= 8'h02;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 2'b00;
      sel_q   <= 3'b000;
      cnt_q   <= 4'd0;
      res_q   <= 8'h00;
      fq_q    <= 8'h02;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flg_q   <= flg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      fq_q    <= fq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flg_d   = flg_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fq_d    = fq_q;
    case (state_q)
      S_IDLE: begin
        if (acc_wr) acc_d = acc_din;
        if (flg_wr) flg_d = norm_flg(flg_din);
        // Direct loads take priority; a pending req simply waits a cycle.
        if (req && !acc_wr && !flg_wr) begin
          a_d     = acc_q;
          b_d     = opnd;
          sel_d   = op;
          c_d     = {flg_q[4], flg_q[0]};
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d   = CNT_INIT;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_res;
          fq_d    = norm_flg(alu_flg);
          state_d = S_WBACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WBACK: begin
        flg_d = fq_q;
        if (sel_q != OP_CMP) acc_d = res_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack     = (state_q == S_WBACK);
  assign busy    = (state_q != S_IDLE);
  assign acc     = acc_q;
  assign flg     = flg_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_c   = c_q;
  assign alu_sel = sel_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// tb/tb_alu_op_seq.sv - directed scoreboard bench for alu_op_seq (EXEC_CYC=1 and 3)
module tb_alu_op_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 1'b0, req3 = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] opnd = 8'h00;
  logic       acc_wr = 1'b0, flg_wr = 1'b0;
  logic [7:0] acc_din = 8'h00, flg_din = 8'h00;
  logic [7:0] alu_res = 8'h00, alu_flg = 8'h00;

  logic       ack1, busy1, ack3, busy3;
  logic [7:0] acc1, flg1, a1, b1, acc3, flg3, a3, b3;
  logic [1:0] c1, c3;
  logic [2:0] sel1, sel3;

  typedef struct packed {
    logic [7:0] acc;
    logic [7:0] flg;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_seq #(.EXEC_CYC(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .op(op), .opnd(opnd), .ack(ack1), .busy(busy1),
    .acc_wr(acc_wr), .acc_din(acc_din), .flg_wr(flg_wr), .flg_din(flg_din),
    .acc(acc1), .flg(flg1), .alu_a(a1), .alu_b(b1), .alu_c(c1), .alu_sel(sel1),
    .alu_res(alu_res), .alu_flg(alu_flg)
  );

  alu_op_seq #(.EXEC_CYC(3)) u3 (
    .clk(clk), .rst(rst), .req(req3), .op(op), .opnd(opnd), .ack(ack3), .busy(busy3),
    .acc_wr(acc_wr), .acc_din(acc_din), .flg_wr(flg_wr), .flg_din(flg_din),
    .acc(acc3), .flg(flg3), .alu_a(a3), .alu_b(b3), .alu_c(c3), .alu_sel(sel3),
    .alu_res(alu_res), .alu_flg(alu_flg)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] acc_o, input logic [7:0] flg_o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, acc_o, e.acc);
      chk({tag, "_flg"}, flg_o, e.flg);
    end
  endtask

  task automatic run_op1(input string tag, input logic [2:0] o, input logic [7:0] b,
                         input logic [7:0] r, input logic [7:0] f, input logic [7:0] ea,
                         input logic [1:0] ec, input logic [7:0] eacc, input logic [7:0] eflg);
    int cyc;
    op = o; opnd = b; alu_res = r; alu_flg = f; req1 = 1'b1;
    sb.push_back('{acc: eacc, flg: eflg});
    tick;
    req1 = 1'b0; op = ~o; opnd = ~b;
    chk({tag, "_busy"}, busy1, 1);
    chk({tag, "_alu_a"}, a1, ea);
    chk({tag, "_alu_b"}, b1, b);
    chk({tag, "_alu_c"}, c1, ec);
    chk({tag, "_alu_sel"}, sel1, o);
    cyc = 1;
    while (!ack1 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 3);
    tick;
    chk({tag, "_idle"}, busy1, 0);
    pop_chk(tag, acc1, flg1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ack_at;
    int acks;

    tick;
    rst = 1'b0;
    chk("rst_acc", acc1, 8'h00);
    chk("rst_flg", flg1, 8'h02);

    // Direct loads, then an asynchronous reset between edges
    acc_wr = 1'b1; acc_din = 8'h55; flg_wr = 1'b1; flg_din = 8'hFF;
    tick;
    acc_wr = 1'b0; flg_wr = 1'b0;
    chk("load_acc", acc1, 8'h55);
    chk("load_flg_norm", flg1, 8'hD7);
    #3 rst = 1'b1;
    #1;
    chk("async_acc", acc1, 8'h00);
    chk("async_flg", flg1, 8'h02);
    chk("async_busy", busy1, 0);
    chk("async_ack", ack1, 0);
    tick;
    rst = 1'b0;

    // ADD
    acc_wr = 1'b1; acc_din = 8'h03;
    tick;
    acc_wr = 1'b0;
    run_op1("add", 3'b000, 8'h05, 8'h08, 8'h00, 8'h03, 2'b00, 8'h08, 8'h02);

    // CMP keeps acc; then flag normalisation and carry-in latching
    acc_wr = 1'b1; acc_din = 8'h10;
    tick;
    acc_wr = 1'b0;
    run_op1("cmp", 3'b111, 8'h10, 8'h00, 8'h44, 8'h10, 2'b00, 8'h10, 8'h46);
    run_op1("ora", 3'b110, 8'h01, 8'h11, 8'hFF, 8'h10, 2'b00, 8'h11, 8'hD7);
    run_op1("adc", 3'b001, 8'h01, 8'h13, 8'h01, 8'h11, 2'b11, 8'h13, 8'h03);

    // EXEC_CYC=3: only the value present on the final EXEC cycle is captured
    acc_wr = 1'b1; acc_din = 8'h20;
    tick;
    acc_wr = 1'b0;
    op = 3'b000; opnd = 8'h02; alu_res = 8'h11; alu_flg = 8'h00; req3 = 1'b1;
    sb.push_back('{acc: 8'h22, flg: 8'h02});
    tick;
    req3 = 1'b0;
    chk("x3_alu_a", a3, 8'h20);
    nb = 0; ack_at = 0;
    while (busy3 && nb < 30) begin
      nb++;
      if (ack3) ack_at = nb;
      if (nb == 4) alu_res = 8'h22;
      tick;
    end
    chk("x3_busy_cycles", nb, 5);
    chk("x3_ack_cycle", ack_at, 5);
    pop_chk("x3", acc3, flg3);

    // Collision: direct load wins, req accepted one cycle later; loads while busy dropped
    acc_wr = 1'b1; acc_din = 8'h40; req1 = 1'b1;
    op = 3'b000; opnd = 8'h01; alu_res = 8'h41; alu_flg = 8'h00;
    sb.push_back('{acc: 8'h41, flg: 8'h02});
    tick;
    acc_wr = 1'b0;
    chk("col_stall_busy", busy1, 0);
    chk("col_acc", acc1, 8'h40);
    tick;
    req1 = 1'b0;
    chk("col_accept_busy", busy1, 1);
    chk("col_alu_a", a1, 8'h40);
    tick;
    acc_wr = 1'b1; acc_din = 8'h99;
    tick;
    acc_wr = 1'b0;
    chk("col_ack", ack1, 1);
    tick;
    pop_chk("col", acc1, flg1);

    // Abort mid-EXEC, then a clean op with cleared carry-in
    flg_wr = 1'b1; flg_din = 8'h11;
    tick;
    flg_wr = 1'b0;
    op = 3'b010; opnd = 8'h05; alu_res = 8'h3B; alu_flg = 8'h11; req1 = 1'b1;
    sb.push_back('{acc: 8'h3B, flg: 8'h13});
    tick;
    req1 = 1'b0;
    chk("abort_alu_c", c1, 2'b11);
    tick;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_busy", busy1, 0);
    chk("abort_acc", acc1, 8'h00);
    chk("abort_flg", flg1, 8'h02);
    tick;
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (ack1) acks++;
      tick;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_acc_kept", acc1, 8'h00);
    run_op1("post", 3'b000, 8'h07, 8'h07, 8'h00, 8'h00, 2'b00, 8'h07, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
